// File: rtl/linear_interp_x4.sv
// linear_interp_x4
//   4x linear interpolating upsampler. Each accepted input sample produces
//   four output samples stepping linearly from the previously accepted
//   sample to the new one; the fourth output equals the new sample exactly.
//
//   Optional feature: define INTERP_ZOH_EN for zero-order hold (all four
//   outputs equal the new sample). Handshake and timing are unchanged.
//
// Ports
//   i_clk    clock, all state updates on posedge
//   i_rstb   asynchronous active-low reset
//   i_data   signed input sample (DATA_WD)
//   i_valid  upstream has a sample on i_data
//   o_ready  block can accept a sample this cycle
//   o_data   signed interpolated output sample (DATA_WD)
//   o_valid  o_data holds a valid sample
//   i_ready  downstream accepts o_data this cycle
module linear_interp_x4 #(
    parameter int DATA_WD = 16
) (
    input  logic               i_clk,
    input  logic               i_rstb,
    input  logic [DATA_WD-1:0] i_data,
    input  logic               i_valid,
    output logic               o_ready,
    output logic [DATA_WD-1:0] o_data,
    output logic               o_valid,
    input  logic               i_ready
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_EMIT = 1'b1;

    logic                      state;
    logic [2:0]                k;
    logic signed [DATA_WD-1:0] r_prev;
    logic signed [DATA_WD-1:0] r_target;
    logic signed [DATA_WD:0]   r_diff;

    logic                      in_xfer;
    logic                      out_xfer;
    logic                      last_phase;
    logic signed [DATA_WD-1:0] diff_base;
    logic signed [DATA_WD:0]   diff_next;

    logic signed [DATA_WD+2:0] prev_x4;
    logic signed [DATA_WD+2:0] diff_ext;
    logic signed [DATA_WD+2:0] step;
    logic signed [DATA_WD+2:0] acc;
    logic                      unused_acc_bits;

    assign last_phase = (k == 3'd4);
    assign o_valid    = (state == ST_EMIT);
    assign o_ready    = (state == ST_IDLE) || ((state == ST_EMIT) && last_phase && i_ready);
    assign in_xfer    = i_valid && o_ready;
    assign out_xfer   = o_valid && i_ready;

    // A back-to-back burst starts while r_prev is still being updated, so the
    // new difference is taken against the outgoing target instead.
    assign diff_base = (state == ST_IDLE) ? r_prev : r_target;
    assign diff_next = {i_data[DATA_WD-1], i_data} - {diff_base[DATA_WD-1], diff_base};

    // Output is derived from registers only: (4*prev + k*diff) >>> 2.
    // The sum always lies within 4*[prev, target], so bits [DATA_WD+1:2]
    // hold the floored result without overflow.
    assign prev_x4  = {r_prev[DATA_WD-1], r_prev, 2'b00};
    assign diff_ext = {{2{r_diff[DATA_WD]}}, r_diff};

    always_comb begin
        step = '0;
`ifdef INTERP_ZOH_EN
        step = diff_ext <<< 2;
`else
        case (k)
            3'd1:    step = diff_ext;
            3'd2:    step = diff_ext <<< 1;
            3'd3:    step = (diff_ext <<< 1) + diff_ext;
            3'd4:    step = diff_ext <<< 2;
            default: step = '0;
        endcase
`endif
    end

    assign acc             = prev_x4 + step;
    assign o_data          = acc[DATA_WD+1:2];
    assign unused_acc_bits = ^{acc[DATA_WD+2], acc[1:0]};

    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            state    <= ST_IDLE;
            k        <= '0;
            r_prev   <= '0;
            r_target <= '0;
            r_diff   <= '0;
        end else if (state == ST_IDLE) begin
            if (in_xfer) begin
                r_target <= i_data;
                r_diff   <= diff_next;
                k        <= 3'd1;
                state    <= ST_EMIT;
            end
        end else if (out_xfer) begin
            if (!last_phase) begin
                k <= k + 3'd1;
            end else begin
                r_prev <= r_target;
                if (in_xfer) begin
                    r_target <= i_data;
                    r_diff   <= diff_next;
                    k        <= 3'd1;
                end else begin
                    k     <= '0;
                    state <= ST_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_linear_interp_x4.sv
module tb_linear_interp_x4;

    logic        i_clk;
    logic        i_rstb;
    logic [15:0] i_data;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] o_data;
    logic        o_valid;
    logic        i_ready;

    int checks   = 0;
    int failures = 0;
    int expq[$];
    bit cont_watch = 0;
    int gap_count  = 0;

    linear_interp_x4 #(.DATA_WD(16)) dut (
        .i_clk   (i_clk),
        .i_rstb  (i_rstb),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Monitor: a transfer visible at negedge completes on the next posedge.
    always @(negedge i_clk) begin
        if (i_rstb) begin
            if (cont_watch && !o_valid) gap_count++;
            if (o_valid && i_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output got=%0d expected=none", $signed(o_data));
                end else begin
                    int e;
                    e = expq.pop_front();
                    if (int'($signed(o_data)) != e) begin
                        failures++;
                        $display("FAIL out_sample got=%0d expected=%0d", $signed(o_data), e);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        i_rstb = 1'b0;
        #1;
        check("rst_o_valid", int'(o_valid), 0);
        check("rst_o_data", int'($signed(o_data)), 0);
        check("rst_o_ready", int'(o_ready), 1);
        expq.delete();
        @(posedge i_clk);
        #1;
        i_rstb = 1'b1;
    endtask

    // Issue one input sample with its four expected outputs.
    task automatic send(input int v, input int e1, input int e2, input int e3, input int e4);
        bit ok;
`ifdef INTERP_ZOH_EN
        expq.push_back(v); expq.push_back(v); expq.push_back(v); expq.push_back(v);
`else
        expq.push_back(e1); expq.push_back(e2); expq.push_back(e3); expq.push_back(e4);
`endif
        i_valid = 1'b1;
        i_data  = 16'(v);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge i_clk);
            if (o_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            failures++;
            $display("FAIL accept_timeout got=0 expected=1");
        end
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_data  = 16'h5A5A;
    endtask

    task automatic drain_and_check_idle();
        for (int i = 0; i < 100; i++) begin
            if (expq.size() == 0) break;
            @(posedge i_clk);
            #1;
        end
        check("drain_left", expq.size(), 0);
        check("idle_o_valid", int'(o_valid), 0);
        check("idle_o_ready", int'(o_ready), 1);
    endtask

    initial begin
        i_rstb  = 1'b1;
        i_valid = 1'b0;
        i_data  = 16'h1234;
        i_ready = 1'b1;
        #2;

        // Basic burst and return to idle
        do_reset();
        repeat (2) @(posedge i_clk);
        #1;
        send(100, 25, 50, 75, 100);
        drain_and_check_idle();
        send(-100, 50, 0, -50, -100);
        drain_and_check_idle();

        // Floor rounding toward -inf
        do_reset();
        send(3, 0, 1, 2, 3);
        drain_and_check_idle();
        do_reset();
        send(-3, -1, -2, -3, -3);
        drain_and_check_idle();

        // Full-scale swing
        send(-32768, -8195, -16386, -24577, -32768);
        drain_and_check_idle();
        send(32767, -16385, -1, 16383, 32767);
        drain_and_check_idle();

        // Back-to-back, output continuously valid
        do_reset();
        send(4, 1, 2, 3, 4);
        cont_watch = 1;
        send(8, 5, 6, 7, 8);
        for (int i = 0; i < 100; i++) begin
            if (expq.size() == 0) break;
            @(posedge i_clk);
            #1;
        end
        cont_watch = 0;
        check("b2b_gaps", gap_count, 0);
        drain_and_check_idle();

        // Back-to-back with backpressure at output 6
        do_reset();
        send(4, 1, 2, 3, 4);
        send(8, 5, 6, 7, 8);
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
`ifdef INTERP_ZOH_EN
            check("hold_data", int'($signed(o_data)), 8);
`else
            check("hold_data", int'($signed(o_data)), 6);
`endif
            check("hold_valid", int'(o_valid), 1);
        end
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
        drain_and_check_idle();

        // Reset mid-burst, then interpolate from zero
        do_reset();
        send(40, 10, 20, 30, 40);
        @(posedge i_clk);
        #1;
        do_reset();
        send(8, 2, 4, 6, 8);
        drain_and_check_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
